// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the requester count, index width, FSM encoding and a decode helper.
package arb_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] idx2hot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr (mod 8).
// Ports: req[7:0], ptr[2:0] in; found, idx[2:0] out.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] off;

    // Rotate so that requester ptr lands on bit 0.
    assign rot = NREQ'({req, req} >> ptr);

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = IDXW'(k);
                found = 1'b1;
            end
        end
    end

    assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and hold timeout.
// Ports: clk, rst_n, en, req[7:0], done in; gnt[7:0], gnt_idx[2:0], gnt_valid, timeout out.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_EN  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            to_q, to_d;

    logic            found;
    logic [IDXW-1:0] pick;
    logic            expire;
    logic            rel;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    assign expire = (HOLD_EN != 0) && (cnt_q == HOLD_LAST);
    assign rel    = done || !req[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = GRANT;
                    idx_d   = pick;
                    gnt_d   = idx2hot(pick);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel || expire) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = idx_q + IDXW'(1);
                    // Timeout flags only a release forced by the hold limit.
                    to_d    = expire && !rel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = to_q;

endmodule
